// File: rtl/settle_avg_monitor.sv
// Settle/average run-time checker: waits for all channels to enter target+/-tol,
// averages 2^LOG2_SAMP valid samples per channel, then reports pass/fail with a cause code.
module settle_avg_monitor #(
  parameter int NCH       = 2,
  parameter int DW        = 16,
  parameter int LOG2_SAMP = 8,
  parameter int TMO_W     = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                smpl_vld,
  input  logic [NCH*DW-1:0]   smpl_data,
  input  logic [DW-1:0]       target,
  input  logic [DW-1:0]       tol,
  input  logic [DW-1:0]       diff_lim,
  input  logic [TMO_W-1:0]    timeout,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [1:0]          fail_code,
  output logic [NCH*DW-1:0]   avg_out,
  output logic [TMO_W-1:0]    settle_cnt
);

  localparam int AW   = DW + LOG2_SAMP;
  localparam int CW   = LOG2_SAMP + 1;
  localparam int IDX1 = (NCH >= 2) ? 1 : 0;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << LOG2_SAMP) - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, AVG, REPORT} state_t;

  state_t                 state;
  logic signed [DW-1:0]   target_q;
  logic [DW-1:0]          tol_q;
  logic [DW-1:0]          diff_lim_q;
  logic [TMO_W-1:0]       timeout_q;
  logic signed [AW-1:0]   acc [NCH];
  logic [CW-1:0]          smp_cnt;

  logic signed [DW-1:0]   smp     [NCH];
  logic signed [AW-1:0]   acc_nxt [NCH];
  logic signed [DW-1:0]   avg_nxt [NCH];
  logic                   all_in;
  logic                   avg_oob;
  logic                   imbal;
  logic [TMO_W:0]         cnt_p1;

  // |a-b| evaluated one bit wider so extreme operands cannot wrap
  function automatic logic [DW:0] abs_diff(input logic signed [DW-1:0] a,
                                           input logic signed [DW-1:0] b);
    logic signed [DW:0] d;
    d = {a[DW-1], a} - {b[DW-1], b};
    return d[DW] ? (DW+1)'(-d) : (DW+1)'(d);
  endfunction

  function automatic logic in_band(input logic signed [DW-1:0] x,
                                   input logic signed [DW-1:0] c,
                                   input logic [DW-1:0]        t);
    return abs_diff(x, c) <= {1'b0, t};
  endfunction

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (&v) ? v : v + TMO_W'(1);
  endfunction

  always_comb begin
    all_in  = 1'b1;
    avg_oob = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      smp[k]     = smpl_data[k*DW +: DW];
      acc_nxt[k] = acc[k] + AW'(smp[k]);
      avg_nxt[k] = DW'(acc_nxt[k] >>> LOG2_SAMP);
      if (!in_band(smp[k], target_q, tol_q))     all_in  = 1'b0;
      if (!in_band(avg_nxt[k], target_q, tol_q)) avg_oob = 1'b1;
    end
    imbal  = (NCH >= 2) && (abs_diff(avg_nxt[0], avg_nxt[IDX1]) > {1'b0, diff_lim_q});
    cnt_p1 = {1'b0, settle_cnt} + (TMO_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_code  <= 2'b00;
      avg_out    <= '0;
      settle_cnt <= '0;
      target_q   <= '0;
      tol_q      <= '0;
      diff_lim_q <= '0;
      timeout_q  <= '0;
      smp_cnt    <= '0;
      for (int k = 0; k < NCH; k++) acc[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort is meaningless here, so a coincident start still launches a run
          if (start) begin
            target_q   <= target;
            tol_q      <= tol;
            diff_lim_q <= diff_lim;
            timeout_q  <= timeout;
            pass       <= 1'b0;
            fail_code  <= 2'b00;
            avg_out    <= '0;
            settle_cnt <= '0;
            smp_cnt    <= '0;
            for (int k = 0; k < NCH; k++) acc[k] <= '0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            settle_cnt <= sat_inc(settle_cnt);
            if (smpl_vld && all_in) begin
              state <= AVG;
            end else if ((timeout_q != '0) && (cnt_p1 == {1'b0, timeout_q})) begin
              fail_code <= 2'b01;
              pass      <= 1'b0;
              done      <= 1'b1;
              state     <= REPORT;
            end
          end
        end
        AVG: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (smpl_vld) begin
            for (int k = 0; k < NCH; k++) acc[k] <= acc_nxt[k];
            smp_cnt <= smp_cnt + CW'(1);
            if (smp_cnt == LAST_CNT) begin
              for (int k = 0; k < NCH; k++) avg_out[k*DW +: DW] <= avg_nxt[k];
              if (avg_oob)    fail_code <= 2'b10;
              else if (imbal) fail_code <= 2'b11;
              else            fail_code <= 2'b00;
              pass  <= !avg_oob && !imbal;
              done  <= 1'b1;
              state <= REPORT;
            end
          end
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_settle_avg_monitor.sv
// Scoreboard bench for settle_avg_monitor: directed runs push expected reports,
// per-instance monitors pop and compare on every done pulse.
module tb_settle_avg_monitor;

  localparam int DW    = 16;
  localparam int TMO_W = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, start2, abort, smpl_vld;
  logic [2*DW-1:0]   smpl_data;
  logic [DW-1:0]     target, tol, diff_lim;
  logic [TMO_W-1:0]  timeout;

  logic              busy, done, pass;
  logic [1:0]        fail_code;
  logic [2*DW-1:0]   avg_out;
  logic [TMO_W-1:0]  settle_cnt;

  logic              busy2, done2, pass2;
  logic [1:0]        fail_code2;
  logic [2*DW-1:0]   avg_out2;
  logic [TMO_W-1:0]  settle_cnt2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [1:0] code;
    logic       ok;
    int         a0;
    int         a1;
    int         scnt;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  settle_avg_monitor #(.NCH(2), .DW(DW), .LOG2_SAMP(8), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .smpl_vld(smpl_vld), .smpl_data(smpl_data), .target(target), .tol(tol),
    .diff_lim(diff_lim), .timeout(timeout), .busy(busy), .done(done),
    .pass(pass), .fail_code(fail_code), .avg_out(avg_out), .settle_cnt(settle_cnt)
  );

  settle_avg_monitor #(.NCH(2), .DW(DW), .LOG2_SAMP(1), .TMO_W(TMO_W)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
    .smpl_vld(smpl_vld), .smpl_data(smpl_data), .target(target), .tol(tol),
    .diff_lim(diff_lim), .timeout(timeout), .busy(busy2), .done(done2),
    .pass(pass2), .fail_code(fail_code2), .avg_out(avg_out2), .settle_cnt(settle_cnt2)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare(input exp_t e, input logic [1:0] fc, input logic p,
                         input logic [2*DW-1:0] av, input logic [TMO_W-1:0] sc);
    check({e.name, ".fail_code"}, int'(fc), int'(e.code));
    check({e.name, ".pass"}, int'(p), int'(e.ok));
    check({e.name, ".avg0"}, int'($signed(av[DW-1:0])), e.a0);
    check({e.name, ".avg1"}, int'($signed(av[2*DW-1:DW])), e.a1);
    check({e.name, ".settle_cnt"}, int'(sc), e.scnt);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q1.size() == 0) check("unexpected_done", 1, 0);
      else compare(q1.pop_front(), fail_code, pass, avg_out, settle_cnt);
    end
    if (rst_n && done2) begin
      if (q2.size() == 0) check("unexpected_done2", 1, 0);
      else compare(q2.pop_front(), fail_code2, pass2, avg_out2, settle_cnt2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_smp(input int c0, input int c1);
    logic [DW-1:0] a, b;
    a = DW'(c0);
    b = DW'(c1);
    smpl_data = {b, a};
  endtask

  task automatic expect1(input string nm, input logic [1:0] c, input logic p,
                         input int a0, input int a1, input int sc);
    exp_t e;
    e.name = nm; e.code = c; e.ok = p; e.a0 = a0; e.a1 = a1; e.scnt = sc;
    q1.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (!done && cyc < max) begin
      tick();
      cyc++;
    end
    if (!done) check("wait_done_timeout", 0, 1);
  endtask

  // settle on {0,0} for one cycle, then average constant {c0,c1}
  task automatic settle_then(input int c0, input int c1);
    int cyc;
    set_smp(0, 0);
    smpl_vld = 1'b1;
    pulse_start();
    tick();
    set_smp(c0, c1);
    wait_done(400, cyc);
    tick();
  endtask

  initial begin
    int cyc;
    exp_t e;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; abort = 1'b0; smpl_vld = 1'b0;
    smpl_data = '0; target = '0; tol = 16'd200; diff_lim = 16'd300; timeout = '0;
    repeat (3) tick();
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.pass", int'(pass), 0);
    check("rst.fail_code", int'(fail_code), 0);
    check("rst.avg_out", int'(avg_out), 0);
    check("rst.settle_cnt", int'(settle_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Test 1: constant {50,-30}; stray starts in AVG and REPORT must be ignored
    expect1("t1", 2'b00, 1'b1, 50, -30, 1);
    set_smp(50, -30);
    smpl_vld = 1'b1;
    pulse_start();
    check("t1.busy_after_start", int'(busy), 1);
    cyc = 0;
    while (!done && cyc < 400) begin
      if (cyc == 100) begin start = 1'b1; target = 16'd5000; end
      if (cyc == 101) begin start = 1'b0; target = '0; end
      tick();
      cyc++;
    end
    check("t1.latency", cyc, 257);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t1.busy_idle", int'(busy), 0);
    tick();

    // Test 2: never settles, timeout 500
    expect1("t2", 2'b01, 1'b0, 0, 0, 500);
    set_smp(1000, 1000);
    timeout = 20'd500;
    pulse_start();
    wait_done(700, cyc);
    check("t2.latency", cyc, 500);
    check("t2.busy_at_done", int'(busy), 1);
    tick();
    check("t2.busy_after_done", int'(busy), 0);
    timeout = '0;

    // Test 3: averages out of band
    expect1("t3", 2'b10, 1'b0, 300, 300, 1);
    settle_then(300, 300);

    // Test 4: imbalance, then same averages within a wider diff limit
    diff_lim = 16'd150;
    expect1("t4a", 2'b11, 1'b0, 150, -150, 1);
    settle_then(150, -150);
    diff_lim = 16'd300;
    expect1("t4b", 2'b00, 1'b1, 150, -150, 1);
    set_smp(0, 0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("t4b.start_with_abort", int'(busy), 1);
    tick();
    set_smp(150, -150);
    wait_done(400, cyc);
    tick();

    // Test 5: floor of negative average on the 2-sample instance, with a gap
    e.name = "t5"; e.code = 2'b00; e.ok = 1'b1; e.a0 = -3; e.a1 = 0; e.scnt = 1;
    q2.push_back(e);
    set_smp(0, 0);
    smpl_vld = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    set_smp(-3, 0);
    tick();
    smpl_vld = 1'b0;
    set_smp(100, 0);
    tick();
    smpl_vld = 1'b1;
    set_smp(-2, 0);
    cyc = 0;
    while (!done2 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("t5.latency", cyc, 1);
    tick();
    check("t5.busy_idle", int'(busy2), 0);

    // Test 6: abort mid-average, no done expected
    set_smp(0, 0);
    pulse_start();
    repeat (101) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6.busy_after_abort", int'(busy), 0);
    repeat (300) tick();
    check("t6.still_idle", int'(busy), 0);

    // Reset asserted mid-average clears outputs without a clock edge
    pulse_start();
    repeat (50) tick();
    rst_n = 1'b0;
    #2;
    check("rstmid.busy", int'(busy), 0);
    check("rstmid.done", int'(done), 0);
    check("rstmid.pass", int'(pass), 0);
    check("rstmid.fail_code", int'(fail_code), 0);
    check("rstmid.avg_out", int'(avg_out), 0);
    check("rstmid.settle_cnt", int'(settle_cnt), 0);
    check("rstmid.pass2", int'(pass2), 0);
    check("rstmid.avg_out2", int'(avg_out2), 0);
    tick();
    rst_n = 1'b1;
    repeat (300) tick();

    check("q1.pending", q1.size(), 0);
    check("q2.pending", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
